// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by fetch_buffer and fetch_unit.
package fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          PC_INCR    = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        FLUSH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, redirect input and decode handshake.
// master = fetch unit side, slave = memory/decode/branch environment.
interface fetch_unit_if #(
    parameter int XLEN = 32
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            misalign_err;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, pc_src, pc_target, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, misalign_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, pc_src, pc_target, instr_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetched instructions with head presented combinationally.
// flush empties the FIFO and overrides any push/pop in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int  BUF_DEPTH = 2,
    parameter type entry_t   = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(BUF_DEPTH):0] count,
    output entry_t                     head
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

`ifndef SYNTHESIS
    push_when_full: assert property (@(posedge clk) disable iff (rst)
        (push && !flush) |-> (count != CNT_W'(BUF_DEPTH)));
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// buffers returned words for decode. Build option: FETCH_MISALIGN_CHK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    fetch_state_t     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  redir_pc;
    logic             misalign_q;
    logic             bad_target;
    logic             halt_next;
    logic             outstanding;
    logic             has_room;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           push_entry;

`ifdef FETCH_MISALIGN_CHK_EN
    assign bad_target = bus.pc_src && (bus.pc_target[1:0] != 2'b00);
`else
    assign bad_target = 1'b0;
`endif
    // PC stays word aligned; a misaligned target only matters to the check above.
    assign redir_pc  = bus.pc_target & ~XLEN'(3);
    assign halt_next = misalign_q || bad_target;

    assign outstanding        = (state == WAIT) || (state == FLUSH);
    assign has_room           = (count + CNT_W'(outstanding)) < CNT_W'(BUF_DEPTH);
    assign bus.imem_req_valid = (state == FETCH) && has_room && !bus.pc_src;
    assign bus.imem_addr      = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // A response landing in a redirect cycle is stale and never enters the buffer.
    assign push       = (state == WAIT) && bus.imem_rsp_valid && !bus.pc_src;
    assign pop        = bus.instr_valid && bus.instr_ready && !bus.pc_src;
    assign push_entry = '{instr: bus.imem_rsp_data, pc: req_pc};

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH),
        .entry_t   (entry_t)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.pc_src),
        .count     (count),
        .head      (head)
    );

    assign bus.instr_valid  = (count != '0);
    assign bus.instr        = bus.instr_valid ? head.instr : NOP_INSTR;
    assign bus.instr_pc     = bus.instr_valid ? head.pc : RESET_PC;
    assign bus.misalign_err = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            if (bus.pc_src) begin
                pc <= redir_pc;
                if (bad_target)
                    misalign_q <= 1'b1;
            end else if (req_fire) begin
                req_pc <= pc;
                pc     <= pc + XLEN'(PC_INCR);
            end

            case (state)
                IDLE: begin
                    if (!halt_next)
                        state <= FETCH;
                end
                FETCH: begin
                    if (bad_target)
                        state <= IDLE;
                    else if (req_fire)
                        state <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_rsp_valid)
                        state <= halt_next ? IDLE : FETCH;
                    else if (bus.pc_src)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // Redirects here keep waiting; the pending response is still discarded.
                    if (bus.imem_rsp_valid)
                        state <= halt_next ? IDLE : FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
